// File: rtl/branch_predictor.sv
// branch_predictor: 2-bit saturating-counter direction predictor.
// Resolves conditional branches in execute from the comparator's eq/lt flags,
// flags mispredicts, trains the counter table and predicts for the fetch PC.
// Optional statistics counters are built only when BRANCH_PRED_STATS_EN is defined;
// otherwise stat_branches/stat_mispredicts are tied to zero.
module branch_predictor #(
   parameter int INDEX_BITS = 6,
   parameter int PC_WIDTH   = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                fetch_valid,
   input  logic                fetch_stall,
   input  logic [PC_WIDTH-1:0] fetch_pc,
   output logic                pred_valid,
   output logic                pred_taken,
   input  logic                ex_valid,
   input  logic                ex_is_branch,
   input  logic [PC_WIDTH-1:0] ex_pc,
   input  logic [2:0]          ex_funct3,
   input  logic                ex_br_eq,
   input  logic                ex_br_lt,
   input  logic                ex_pred_taken,
   output logic                ex_br_un,
   output logic                ex_taken,
   output logic                mispredict,
   output logic [31:0]         stat_branches,
   output logic [31:0]         stat_mispredicts
);

   localparam int unsigned DEPTH = 1 << INDEX_BITS;

   logic [1:0]            cnt [DEPTH];
   logic [INDEX_BITS-1:0] fetch_idx;
   logic [INDEX_BITS-1:0] ex_idx;
   logic                  dir;
   logic                  legal;
   logic                  upd;
   logic [1:0]            cnt_ex;
   logic [1:0]            cnt_new;
   logic [1:0]            cnt_fetch;
   logic                  unused_pc_bits;

   assign fetch_idx = fetch_pc[INDEX_BITS+1:2];
   assign ex_idx    = ex_pc[INDEX_BITS+1:2];

   // PC bits outside the index field are intentionally ignored (no tags).
   assign unused_pc_bits = &{1'b0, fetch_pc[PC_WIDTH-1:INDEX_BITS+2], fetch_pc[1:0],
                             ex_pc[PC_WIDTH-1:INDEX_BITS+2], ex_pc[1:0]};

   // Decode funct3 into comparator select, legality and resolved direction
   always_comb begin
      ex_br_un = (ex_funct3[2:1] == 2'b11);
      legal    = 1'b1;
      dir      = 1'b0;
      case (ex_funct3)
         3'b000:          dir = ex_br_eq;
         3'b001:          dir = !ex_br_eq;
         3'b100, 3'b110:  dir = ex_br_lt;
         3'b101, 3'b111:  dir = !ex_br_lt;
         default: begin
            legal = 1'b0;
            dir   = 1'b0;
         end
      endcase
   end

   assign upd        = ex_valid & ex_is_branch & legal;
   assign ex_taken   = ex_valid & ex_is_branch & dir;
   assign mispredict = ex_valid & ex_is_branch & (ex_taken != ex_pred_taken);

   // Saturating update value for the execute entry, plus write-first bypass to fetch
   always_comb begin
      cnt_ex = cnt[ex_idx];
      if (ex_taken)
         cnt_new = (cnt_ex == 2'b11) ? 2'b11 : cnt_ex + 2'b01;
      else
         cnt_new = (cnt_ex == 2'b00) ? 2'b00 : cnt_ex - 2'b01;
      if (upd && (fetch_idx == ex_idx))
         cnt_fetch = cnt_new;
      else
         cnt_fetch = cnt[fetch_idx];
   end

   // Counter table: reset to weak-not-taken, trained by resolved branches
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < DEPTH; i++)
            cnt[i] <= 2'b01;
      end else if (upd) begin
         cnt[ex_idx] <= cnt_new;
      end
   end

   // Fetch-side prediction registers, held while fetch is stalled
   always_ff @(posedge clk) begin
      if (rst) begin
         pred_valid <= 1'b0;
         pred_taken <= 1'b0;
      end else if (!fetch_stall) begin
         pred_valid <= fetch_valid;
         pred_taken <= fetch_valid & cnt_fetch[1];
      end
   end

`ifdef BRANCH_PRED_STATS_EN
   // Free-running statistics counters (wrap naturally at 2**32)
   always_ff @(posedge clk) begin
      if (rst) begin
         stat_branches    <= '0;
         stat_mispredicts <= '0;
      end else begin
         if (upd)
            stat_branches <= stat_branches + 32'd1;
         if (mispredict)
            stat_mispredicts <= stat_mispredicts + 32'd1;
      end
   end
`else
   assign stat_branches    = '0;
   assign stat_mispredicts = '0;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: directed, table-driven bench for branch_predictor
// (INDEX_BITS = 6). Checks stat ports against BRANCH_PRED_STATS_EN.
module tb_branch_predictor;

   logic        clk;
   logic        rst;
   logic        fetch_valid;
   logic        fetch_stall;
   logic [31:0] fetch_pc;
   logic        pred_valid;
   logic        pred_taken;
   logic        ex_valid;
   logic        ex_is_branch;
   logic [31:0] ex_pc;
   logic [2:0]  ex_funct3;
   logic        ex_br_eq;
   logic        ex_br_lt;
   logic        ex_pred_taken;
   logic        ex_br_un;
   logic        ex_taken;
   logic        mispredict;
   logic [31:0] stat_branches;
   logic [31:0] stat_mispredicts;

   int n_vec = 0;
   int n_err = 0;
   int exp_br = 0;
   int exp_mp = 0;

   branch_predictor #(.INDEX_BITS(6), .PC_WIDTH(32)) dut (
      .clk              (clk),
      .rst              (rst),
      .fetch_valid      (fetch_valid),
      .fetch_stall      (fetch_stall),
      .fetch_pc         (fetch_pc),
      .pred_valid       (pred_valid),
      .pred_taken       (pred_taken),
      .ex_valid         (ex_valid),
      .ex_is_branch     (ex_is_branch),
      .ex_pc            (ex_pc),
      .ex_funct3        (ex_funct3),
      .ex_br_eq         (ex_br_eq),
      .ex_br_lt         (ex_br_lt),
      .ex_pred_taken    (ex_pred_taken),
      .ex_br_un         (ex_br_un),
      .ex_taken         (ex_taken),
      .mispredict       (mispredict),
      .stat_branches    (stat_branches),
      .stat_mispredicts (stat_mispredicts)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [2:0] funct3;
      logic       eq;
      logic       lt;
      logic       valid;
      logic       is_branch;
      logic       pred;
      logic       exp_un;
      logic       exp_taken;
      logic       exp_misp;
   } vec_t;

   vec_t vecs [14];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Resolve a BEQ at pc with the given outcome and travelling prediction
   task automatic train(input logic [31:0] pc, input logic taken, input logic pred);
      ex_valid      = 1'b1;
      ex_is_branch  = 1'b1;
      ex_pc         = pc;
      ex_funct3     = 3'b000;
      ex_br_eq      = taken;
      ex_br_lt      = 1'b0;
      ex_pred_taken = pred;
      exp_br++;
      if (taken != pred) exp_mp++;
      step();
      ex_valid = 1'b0;
   endtask

   // Fetch pc for one cycle and check the registered prediction
   task automatic fetch_check(input string name, input logic [31:0] pc, input logic exp);
      fetch_valid = 1'b1;
      fetch_pc    = pc;
      step();
      fetch_valid = 1'b0;
      check({name, ".valid"}, {31'd0, pred_valid}, 32'd1);
      check({name, ".taken"}, {31'd0, pred_taken}, {31'd0, exp});
   endtask

   task automatic check_stats(input string name);
`ifdef BRANCH_PRED_STATS_EN
      check({name, ".stat_br"}, stat_branches, exp_br);
      check({name, ".stat_mp"}, stat_mispredicts, exp_mp);
`else
      check({name, ".stat_br"}, stat_branches, 32'd0);
      check({name, ".stat_mp"}, stat_mispredicts, 32'd0);
`endif
   endtask

   initial begin
      //          funct3  eq    lt    valid br    pred  un    taken misp
      vecs[0]  = '{3'b000, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
      vecs[1]  = '{3'b000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[2]  = '{3'b001, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
      vecs[3]  = '{3'b001, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
      vecs[4]  = '{3'b100, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
      vecs[5]  = '{3'b110, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
      vecs[6]  = '{3'b110, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
      vecs[7]  = '{3'b101, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
      vecs[8]  = '{3'b111, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      vecs[9]  = '{3'b111, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
      vecs[10] = '{3'b010, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
      vecs[11] = '{3'b011, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[12] = '{3'b000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      vecs[13] = '{3'b000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

      rst           = 1'b1;
      fetch_valid   = 1'b0;
      fetch_stall   = 1'b0;
      fetch_pc      = 32'h0;
      ex_valid      = 1'b0;
      ex_is_branch  = 1'b0;
      ex_pc         = 32'h40;
      ex_funct3     = 3'b000;
      ex_br_eq      = 1'b0;
      ex_br_lt      = 1'b0;
      ex_pred_taken = 1'b0;
      step();
      step();

      // Combinational execute decode, applied while reset holds the table
      for (int i = 0; i < 14; i++) begin
         ex_funct3     = vecs[i].funct3;
         ex_br_eq      = vecs[i].eq;
         ex_br_lt      = vecs[i].lt;
         ex_valid      = vecs[i].valid;
         ex_is_branch  = vecs[i].is_branch;
         ex_pred_taken = vecs[i].pred;
         #1;
         check($sformatf("vec%0d.br_un", i), {31'd0, ex_br_un}, {31'd0, vecs[i].exp_un});
         check($sformatf("vec%0d.taken", i), {31'd0, ex_taken}, {31'd0, vecs[i].exp_taken});
         check($sformatf("vec%0d.misp", i), {31'd0, mispredict}, {31'd0, vecs[i].exp_misp});
      end
      ex_valid = 1'b0;
      step();

      check("rst.pred_valid", {31'd0, pred_valid}, 32'd0);
      check("rst.pred_taken", {31'd0, pred_taken}, 32'd0);
      check_stats("rst");

      rst = 1'b0;
      fetch_check("first_fetch", 32'h100, 1'b0);

      // Counter 01 -> 10 via BEQ taken with predicted NT
      ex_valid = 1'b1; ex_is_branch = 1'b1; ex_pc = 32'h100; ex_funct3 = 3'b000;
      ex_br_eq = 1'b1; ex_pred_taken = 1'b0;
      #1;
      check("beq.taken", {31'd0, ex_taken}, 32'd1);
      check("beq.misp", {31'd0, mispredict}, 32'd1);
      ex_valid = 1'b0;
      train(32'h100, 1'b1, 1'b0);
      fetch_check("after_beq", 32'h100, 1'b1);

      // Saturate high, then walk down and saturate low
      for (int i = 0; i < 4; i++) train(32'h100, 1'b1, 1'b1);
      train(32'h100, 1'b0, 1'b1);
      fetch_check("sat_hi_then_nt", 32'h100, 1'b1);
      train(32'h100, 1'b0, 1'b1);
      train(32'h100, 1'b0, 1'b0);
      fetch_check("down_to_00", 32'h100, 1'b0);
      train(32'h100, 1'b0, 1'b0);
      fetch_check("sat_lo", 32'h100, 1'b0);
      train(32'h100, 1'b1, 1'b0);
      fetch_check("sat_lo_plus1", 32'h100, 1'b0);

      // Counter 01 -> 11, alias 0x200 shares index 0
      train(32'h100, 1'b1, 1'b0);
      train(32'h100, 1'b1, 1'b1);
      fetch_check("alias_0x200", 32'h200, 1'b1);

      // Neighbouring entry untouched
      fetch_check("other_idx", 32'h104, 1'b0);

      // 11 -> 01, then same-cycle update/fetch must see 10
      train(32'h100, 1'b0, 1'b1);
      train(32'h100, 1'b0, 1'b1);
      fetch_check("pre_bypass", 32'h100, 1'b0);
      fetch_valid = 1'b1; fetch_pc = 32'h100;
      train(32'h100, 1'b1, 1'b0);
      fetch_valid = 1'b0;
      check("bypass.taken", {31'd0, pred_taken}, 32'd1);

      // Stall holds prediction registers while fetch_valid drops
      fetch_check("pre_stall", 32'h100, 1'b1);
      fetch_stall = 1'b1;
      step();
      check("stall.valid", {31'd0, pred_valid}, 32'd1);
      check("stall.taken", {31'd0, pred_taken}, 32'd1);
      fetch_stall = 1'b0;
      step();
      check("unstall.valid", {31'd0, pred_valid}, 32'd0);

      // Illegal funct3: mispredicts, no training (counter stays 10)
      ex_valid = 1'b1; ex_is_branch = 1'b1; ex_pc = 32'h100; ex_funct3 = 3'b010;
      ex_br_eq = 1'b1; ex_br_lt = 1'b1; ex_pred_taken = 1'b1;
      #1;
      check("illegal.taken", {31'd0, ex_taken}, 32'd0);
      check("illegal.misp", {31'd0, mispredict}, 32'd1);
      exp_mp++;
      step();
      ex_valid = 1'b0;
      fetch_check("illegal_no_train", 32'h100, 1'b1);
      check_stats("run");

      // Reset coinciding with an update discards it; table returns to 01
      rst = 1'b1;
      fetch_valid = 1'b1; fetch_pc = 32'h100;
      ex_valid = 1'b1; ex_is_branch = 1'b1; ex_pc = 32'h100; ex_funct3 = 3'b000;
      ex_br_eq = 1'b1; ex_pred_taken = 1'b0;
      step();
      rst = 1'b0; fetch_valid = 1'b0; ex_valid = 1'b0;
      exp_br = 0; exp_mp = 0;
      check("midrst.pred_valid", {31'd0, pred_valid}, 32'd0);
      check("midrst.pred_taken", {31'd0, pred_taken}, 32'd0);
      check_stats("midrst");
      fetch_check("post_rst", 32'h100, 1'b0);
      train(32'h100, 1'b1, 1'b0);
      fetch_check("post_rst_train", 32'h100, 1'b1);
      check_stats("final");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
